// File: rtl/bus_booking_ctrl.sv
// bus_booking_ctrl
//   Seat-booking session controller with a persistent occupancy map.
//   A session runs IDLE -> SEL_SEAT -> PAY -> DONE. It leaves early to FAIL
//   when the bus is sold out or a waiting step times out, and to IDLE on cancel.
//   Seats can be released in any state.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   start                     begin a session (IDLE only)
//   seat_valid, seat_idx      seat request (SEL_SEAT only)
//   pay_ok                    payment confirmed (PAY only)
//   cancel                    abort session (SEL_SEAT, PAY)
//   rel_valid, rel_idx        release a booked seat (any state)
//   state                     0 IDLE, 1 SEL_SEAT, 2 PAY, 3 DONE, 4 FAIL
//   busy, done, fail, err     status / one-cycle pulses
//   fail_code                 1 sold out, 2 timeout; held until next FAIL
//   booked_idx                seat held or committed by current/last session
//   seat_map, free_count      occupancy bitmap and number of free seats
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start
// SEL_SEAT | waiting for a valid, free seat request
// PAY      | seat latched in booked_idx, waiting for payment
// DONE     | one cycle, seat committed to seat_map
// FAIL     | one cycle, fail_code tells why
module bus_booking_ctrl #(
  parameter int NUM_SEATS = 16,
  parameter int SEAT_W    = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 seat_valid,
  input  logic [SEAT_W-1:0]    seat_idx,
  input  logic                 pay_ok,
  input  logic                 cancel,
  input  logic                 rel_valid,
  input  logic [SEAT_W-1:0]    rel_idx,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic                 err,
  output logic [SEAT_W-1:0]    booked_idx,
  output logic [NUM_SEATS-1:0] seat_map,
  output logic [SEAT_W:0]      free_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_PAY  = 3'd2,
    S_DONE = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  localparam logic [SEAT_W:0] NUM_SEATS_W = (SEAT_W+1)'(NUM_SEATS);
  localparam logic [7:0]      TMO_LOAD    = 8'(TIMEOUT - 1);

  state_t                st_q;
  // Down-counter: loaded on entry to a waiting state, timeout fires at zero,
  // which lands exactly TIMEOUT cycles after entry.
  logic [7:0]            timer_q;

  logic                  req_in_range;
  logic                  req_taken;
  logic                  req_ok;
  logic                  commit;
  logic [NUM_SEATS-1:0]  map_nxt;
  logic [SEAT_W:0]       used_nxt;
  logic [SEAT_W:0]       free_nxt;

  assign state = st_q;

  always_comb begin
    req_in_range = ({1'b0, seat_idx} < NUM_SEATS_W);
    req_taken    = 1'b0;
    commit       = (st_q == S_PAY) && !cancel && pay_ok;
    map_nxt      = seat_map;
    used_nxt     = '0;
    // Index matching by loop keeps out-of-range indices from touching the map.
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (seat_idx == SEAT_W'(i)) req_taken = seat_map[i];
      if (rel_valid && rel_idx == SEAT_W'(i)) map_nxt[i] = 1'b0;
      // Commit applied after release so it wins on a same-index collision.
      if (commit && booked_idx == SEAT_W'(i)) map_nxt[i] = 1'b1;
    end
    for (int i = 0; i < NUM_SEATS; i++) begin
      used_nxt = used_nxt + {{SEAT_W{1'b0}}, map_nxt[i]};
    end
    free_nxt = NUM_SEATS_W - used_nxt;
    req_ok   = req_in_range && !req_taken;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= S_IDLE;
      timer_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      err        <= 1'b0;
      fail_code  <= 2'd0;
      booked_idx <= '0;
      seat_map   <= '0;
      free_count <= NUM_SEATS_W;
    end else begin
      done       <= 1'b0;
      fail       <= 1'b0;
      err        <= 1'b0;
      seat_map   <= map_nxt;
      free_count <= free_nxt;
      case (st_q)
        S_IDLE: begin
          if (start) begin
            if (free_count != '0) begin
              st_q    <= S_SEL;
              busy    <= 1'b1;
              timer_q <= TMO_LOAD;
            end else begin
              st_q      <= S_FAIL;
              fail      <= 1'b1;
              fail_code <= 2'd1;
            end
          end
        end
        S_SEL: begin
          if (cancel) begin
            st_q <= S_IDLE;
            busy <= 1'b0;
          end else if (seat_valid) begin
            if (req_ok) begin
              st_q       <= S_PAY;
              booked_idx <= seat_idx;
              timer_q    <= TMO_LOAD;
            end else begin
              err <= 1'b1;
              // Saturate so a rejected request on the last cycle still times out next.
              if (timer_q != '0) timer_q <= timer_q - 8'd1;
            end
          end else if (timer_q == '0) begin
            st_q      <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= 2'd2;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_PAY: begin
          if (cancel) begin
            st_q <= S_IDLE;
            busy <= 1'b0;
          end else if (pay_ok) begin
            st_q <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (timer_q == '0) begin
            st_q      <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= 2'd2;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: begin
          st_q <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
